// File: rtl/rc4_pkg.sv
// Shared RC4 datapath definitions: KSA state encoding and S-array geometry.
package rc4_pkg;

    localparam int S_SIZE      = 256;
    localparam int ADDR_W      = 8;
    localparam int KEY_LEN_DEF = 3;

    typedef enum logic [3:0] {
        IDLE,
        READ_I,
        WAIT_I,
        CAP_I,
        READ_J,
        WAIT_J,
        CAP_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

endpackage

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling pass over the single-port S RAM: j += s[i] + key[i mod KEY_LEN],
// then swap s[i]/s[j]. Eight clocks per i; RAM outputs are registered on state entry.
module ksa_swap_fsm
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*KEY_LEN-1:0]  secret_key,
    output logic [ADDR_W-1:0]     address,
    output logic [7:0]            data,
    output logic                  wren,
    input  logic [7:0]            q,
    output logic                  ksa_active,
    output logic                  done_flag
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    ksa_state_t        r_state, w_state_nxt;
    logic [7:0]        r_i, r_j, r_si;
    logic [KW-1:0]     r_k;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_data, w_data_nxt;
    logic              r_wren, w_wren_nxt;
    logic              r_done;
    logic [7:0]        w_j_new;
    logic              w_idle_or_done;

    // key[0] sits in the most significant byte of secret_key
    function automatic logic [7:0] key_byte(input logic [8*KEY_LEN-1:0] key,
                                            input logic [KW-1:0] k);
        return key[8*(KEY_LEN-1-int'(k)) +: 8];
    endfunction

    assign w_j_new        = r_j + q + key_byte(secret_key, r_k);
    assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);

    assign address    = r_addr;
    assign data       = r_data;
    assign wren       = r_wren;
    assign done_flag  = r_done;
    assign ksa_active = !w_idle_or_done;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_wren_nxt  = 1'b0;
        case (r_state)
            IDLE, DONE: if (start) begin
                w_state_nxt = READ_I;
                w_addr_nxt  = '0;
            end
            READ_I: w_state_nxt = WAIT_I;
            WAIT_I: w_state_nxt = CAP_I;
            CAP_I: begin
                w_state_nxt = READ_J;
                w_addr_nxt  = w_j_new;
            end
            READ_J: w_state_nxt = WAIT_J;
            WAIT_J: w_state_nxt = CAP_J;
            CAP_J: begin
                // q holds s[j] this cycle; it goes straight out as the s[i] write data
                w_state_nxt = WR_I;
                w_addr_nxt  = r_i;
                w_data_nxt  = q;
                w_wren_nxt  = 1'b1;
            end
            WR_I: begin
                w_state_nxt = WR_J;
                w_addr_nxt  = r_j;
                w_data_nxt  = r_si;
                w_wren_nxt  = 1'b1;
            end
            WR_J: begin
                if (r_i == 8'hFF) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = READ_I;
                    w_addr_nxt  = r_i + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_si    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wren  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_wren  <= w_wren_nxt;
            if (w_idle_or_done && start) begin
                r_i    <= '0;
                r_j    <= '0;
                r_k    <= '0;
                r_done <= 1'b0;
            end else if (r_state == DONE) begin
                // flag trails the DONE state by one clock
                r_done <= 1'b1;
            end
            if (r_state == CAP_I) begin
                r_si <= q;
                r_j  <= w_j_new;
            end
            if (r_state == WR_J && r_i != 8'hFF) begin
                r_i <= r_i + 8'd1;
                r_k <= (r_k == KW'(KEY_LEN-1)) ? '0 : r_k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Directed bench for ksa_swap_fsm with a behavioural S RAM and a reference KSA.
module tb_ksa_swap_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  address, data, q;
    logic        wren, ksa_active, done_flag;
    logic        ram_init;
    logic [7:0]  mem   [256];
    logic [7:0]  ref_s [256];
    int          ntests = 0;
    int          nfail  = 0;
    int          done_n, wr_err;

    always #5 clk = ~clk;

    ksa_swap_fsm #(.KEY_LEN(3)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .address(address), .data(data), .wren(wren), .q(q),
        .ksa_active(ksa_active), .done_flag(done_flag)
    );

    // one-cycle registered-read RAM; q sampled by the FSM one edge later
    always @(posedge clk) begin
        if (ram_init) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_ram();
        ram_init = 1'b1;
        tick();
        ram_init = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ref_ksa(input logic [23:0] key);
        logic [7:0] j, t;
        for (int a = 0; a < 256; a++) ref_s[a] = 8'(a);
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j = j + ref_s[i] + key[8*(2 - i % 3) +: 8];
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    task automatic chk_ram(input string tag, input logic [23:0] key);
        int bad = 0;
        ref_ksa(key);
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_s[a]) bad++;
        chk(tag, bad, 0);
    endtask

    // steps until done_flag rises or the budget runs out; tracks wren against the 8-state cadence
    task automatic run_pass(input int n0, input int p1, input int p2,
                            output int dn, output int werr);
        dn = -1;
        werr = 0;
        for (int n = n0 + 1; n <= 2100 && dn < 0; n++) begin
            if (n == p1 || n == p2) start = 1'b1;
            tick();
            start = 1'b0;
            if (n < 2048 && wren !== ((n % 8) >= 6)) werr++;
            if (done_flag === 1'b1) dn = n;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ram_init = 1'b0; secret_key = 24'h000000;
        #12;
        chk("rst_address", address, 0);
        chk("rst_data", data, 0);
        chk("rst_wren", wren, 0);
        chk("rst_active", ksa_active, 0);
        chk("rst_done", done_flag, 0);
        @(negedge clk) reset = 1'b0;

        // key 000000: first three iterations, then full pass
        init_ram();
        do_start();
        chk("k0_active", ksa_active, 1);
        chk("k0_addr_n0", address, 0);
        for (int n = 1; n <= 23; n++) begin
            tick();
            case (n)
                6:  chk("k0_wr_i0", {address, data, 7'd0, wren}, {8'd0, 8'd0, 8'd1});
                7:  chk("k0_wr_j0", {address, data, 7'd0, wren}, {8'd0, 8'd0, 8'd1});
                14: chk("k0_wr_i1", {address, data, 7'd0, wren}, {8'd1, 8'd1, 8'd1});
                15: chk("k0_wr_j1", {address, data, 7'd0, wren}, {8'd1, 8'd1, 8'd1});
                22: chk("k0_wr_i2", {address, data, 7'd0, wren}, {8'd2, 8'd3, 8'd1});
                23: chk("k0_wr_j2", {address, data, 7'd0, wren}, {8'd3, 8'd2, 8'd1});
                default: ;
            endcase
        end
        run_pass(23, -1, -1, done_n, wr_err);
        chk("k0_done_cycle", done_n, 2049);
        chk("k0_wren_cadence", wr_err, 0);
        chk("k0_done_wren", wren, 0);
        chk("k0_done_active", ksa_active, 0);
        chk_ram("k0_final_ram", 24'h000000);

        // restart from DONE with key 0F0000
        secret_key = 24'h0F0000;
        init_ram();
        do_start();
        chk("restart_done_clr", done_flag, 0);
        for (int n = 1; n <= 16; n++) tick();
        chk("k0f_s0", mem[0], 15);
        chk("k0f_s15", mem[15], 0);
        run_pass(16, -1, -1, done_n, wr_err);
        chk("k0f_done_cycle", done_n, 2049);
        chk_ram("k0f_final_ram", 24'h0F0000);

        // start pulses while busy must not disturb the pass
        secret_key = 24'h000000;
        init_ram();
        do_start();
        run_pass(0, 10, 500, done_n, wr_err);
        chk("busy_start_cycle", done_n, 2049);
        chk("busy_start_wren", wr_err, 0);
        chk_ram("busy_start_ram", 24'h000000);

        // key 010203: key index wraps back to byte 0 at i=3
        secret_key = 24'h010203;
        init_ram();
        do_start();
        for (int n = 1; n <= 806; n++) begin
            tick();
            if (n == 30) chk("krol_wr_i3", {address, data}, {8'd3, 8'd9});
            if (n == 31) chk("krol_wr_j3", {address, data}, {8'd9, 8'd0});
        end
        chk("mid_wren_before", wren, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_active", ksa_active, 0);
        chk("mid_rst_done", done_flag, 0);
        @(negedge clk) reset = 1'b0;

        init_ram();
        do_start();
        run_pass(0, -1, -1, done_n, wr_err);
        chk("after_rst_cycle", done_n, 2049);
        chk_ram("after_rst_ram", 24'h010203);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
